// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants shared by the fetch unit and the instruction controller.
//   Opcode encodings: the top nibble of an instruction.
//   Fetch FSM state encoding: 2 bits.
//   Default widths, instruction field layout, and the reset value of IR (a NOP).
package cpu_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 8;
   localparam int OPC_W       = 4;   // opcode field = IR[INSTR_W-1 -: OPC_W]
   localparam int OPND_W      = 4;   // operand field = IR[OPND_W-1:0]

   localparam logic [7:0] NOP_INSTR_DEF = 8'h00;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_LDI  = 4'h6,
      OP_JMPI = 4'h7,   // jump to the zero-extended immediate operand
      OP_JMPR = 4'h8,   // jump to the register named by the operand
      OP_LDR  = 4'h9,
      OP_STR  = 4'hA,
      OP_HALT = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      UPDATE = 2'd2,
      HALT   = 2'd3
   } fetchState_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory req/valid handshake.
//   IMemReq   fetch request (fetch unit -> memory)
//   IMemAddr  fetch address (fetch unit -> memory)
//   IMemData  read data     (memory -> fetch unit)
//   IMemValid read data valid this cycle (memory -> fetch unit)
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8
);
   logic               IMemReq;
   logic [PC_W-1:0]    IMemAddr;
   logic [INSTR_W-1:0] IMemData;
   logic               IMemValid;

   modport master (
      output IMemReq, IMemAddr,
      input  IMemData, IMemValid
   );

   modport slave (
      input  IMemReq, IMemAddr,
      output IMemData, IMemValid
   );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// pc_next -- combinational next-PC selection.
//   pc       current program counter
//   operand  instruction operand field (immediate jump target)
//   regData  register-file value (register jump target)
//   loadPC   jump; wins over incPC
//   selPC    jump source: 1 = immediate operand, 0 = regData
//   incPC    PC + 1, wrapping modulo 2^PC_W
//   nextPc   selected next PC (pc itself when nothing is asserted)
// PC_W must be at least 4 so the operand fits.
module pc_next
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [PC_W-1:0]   pc,
   input  logic [OPND_W-1:0] operand,
   input  logic [PC_W-1:0]   regData,
   input  logic              loadPC,
   input  logic              selPC,
   input  logic              incPC,
   output logic [PC_W-1:0]   nextPc
);

   logic [PC_W-1:0] immTarget;

   assign immTarget = PC_W'(operand);

   // if/else rather than ?: so an X/Z select falls through to the
   // "not asserted" branch instead of merging both targets.
   always_comb begin
      nextPc = pc;
      if (loadPC) begin
         if (selPC) nextPc = immTarget;
         else       nextPc = regData;
      end else if (incPC) begin
         nextPc = pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- fetch/sequencing stage in front of the instruction controller.
// Owns PC and IR, fetches over a req/valid handshake, hands Opcode/Operand to
// the controller, then applies its LoadIR/IncPC/SelPC/LoadPC decision.
// Each instruction walks FETCH -> DECODE -> UPDATE; ExecEn is high only in
// UPDATE so the datapath commits exactly once per instruction.
// Ports:
//   Clk, reset          clock (rising edge), asynchronous active-high reset
//   imem                instruction-memory handshake (master side)
//   LoadIR              continue fetching after this instruction (0 = halt)
//   IncPC/SelPC/LoadPC  next-PC controls, sampled on the closing edge of UPDATE
//   RegData             register jump target
//   Opcode, Operand     IR fields to the controller
//   PC                  program counter
//   ExecEn              datapath commit enable
//   Halted              HALT state reached; only reset leaves it
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                 PC_W      = PC_W_DEF,
   parameter int                 INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic                Clk,
   input  logic                reset,
   fetch_unit_if.master        imem,
   input  logic                LoadIR,
   input  logic                IncPC,
   input  logic                SelPC,
   input  logic                LoadPC,
   input  logic [PC_W-1:0]     RegData,
   output logic [OPC_W-1:0]    Opcode,
   output logic [OPND_W-1:0]   Operand,
   output logic [PC_W-1:0]     PC,
   output logic                ExecEn,
   output logic                Halted
);

   fetchState_t        state, nextState;
   logic [PC_W-1:0]    pcReg, pcNextVal;
   logic [INSTR_W-1:0] irReg;
   logic               fetchReq, irLoad, pcLoad;

   // ---------------- state register ----------------
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= nextState;
   end

   // ---------------- next-state logic ----------------
   // An X/Z LoadIR takes the else branch, so an unrecognised opcode halts.
   always_comb begin
      nextState = state;
      case (state)
         FETCH:   if (imem.IMemValid) nextState = DECODE;
         DECODE:  nextState = UPDATE;
         UPDATE:  begin
            if (LoadIR) nextState = FETCH;
            else        nextState = HALT;
         end
         HALT:    nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      fetchReq = 1'b0;
      irLoad   = 1'b0;
      pcLoad   = 1'b0;
      ExecEn   = 1'b0;
      Halted   = 1'b0;
      case (state)
         FETCH: begin
            fetchReq = 1'b1;
            // Data is taken only while requesting, so stray valids elsewhere are ignored.
            irLoad   = imem.IMemValid;
         end
         UPDATE: begin
            ExecEn = 1'b1;
            pcLoad = 1'b1;
         end
         HALT:    Halted = 1'b1;
         default: ;
      endcase
   end

   // ---------------- PC / IR ----------------
   pc_next #(.PC_W(PC_W)) uPcNext (
      .pc      (pcReg),
      .operand (irReg[OPND_W-1:0]),
      .regData (RegData),
      .loadPC  (LoadPC),
      .selPC   (SelPC),
      .incPC   (IncPC),
      .nextPc  (pcNextVal)
   );

   always_ff @(posedge Clk or posedge reset) begin
      if (reset)       pcReg <= '0;
      else if (pcLoad) pcReg <= pcNextVal;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset)       irReg <= NOP_INSTR;
      else if (irLoad) irReg <= imem.IMemData;
   end

   assign imem.IMemReq  = fetchReq;
   assign imem.IMemAddr = pcReg;
   assign PC            = pcReg;
   assign Opcode        = irReg[INSTR_W-1 -: OPC_W];
   assign Operand       = irReg[OPND_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed test of fetch_unit. The bench plays both the
// instruction memory (array + valid strobe) and the controller (static
// LoadIR/IncPC/SelPC/LoadPC per instruction). Expected values are hand-computed.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 8;

   logic          Clk = 1'b0;
   logic          reset;
   logic          LoadIR, IncPC, SelPC, LoadPC;
   logic [7:0]    RegData;
   logic [3:0]    Opcode, Operand;
   logic [7:0]    PC;
   logic          ExecEn, Halted;

   logic [7:0]    mem [256];
   logic          memValid;
   logic [7:0]    expIR;

   int nChecks = 0;
   int nFails  = 0;

   fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

   assign imem.IMemData  = mem[imem.IMemAddr];
   assign imem.IMemValid = memValid;

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(8'h00)) dut (
      .Clk     (Clk),
      .reset   (reset),
      .imem    (imem.master),
      .LoadIR  (LoadIR),
      .IncPC   (IncPC),
      .SelPC   (SelPC),
      .LoadPC  (LoadPC),
      .RegData (RegData),
      .Opcode  (Opcode),
      .Operand (Operand),
      .PC      (PC),
      .ExecEn  (ExecEn),
      .Halted  (Halted)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic setCtrl(input logic ld, input logic inc, input logic sel, input logic jmp,
                          input logic [7:0] rd);
      LoadIR = ld; IncPC = inc; SelPC = sel; LoadPC = jmp; RegData = rd;
   endtask

   task automatic checkReset(input string t);
      chk({t, "_req"},    32'(imem.IMemReq),  1);
      chk({t, "_addr"},   32'(imem.IMemAddr), 0);
      chk({t, "_opcode"}, 32'(Opcode),        0);
      chk({t, "_operand"},32'(Operand),       0);
      chk({t, "_pc"},     32'(PC),            0);
      chk({t, "_exec"},   32'(ExecEn),        0);
      chk({t, "_halted"}, 32'(Halted),        0);
   endtask

   // One instruction, entered just after the edge that put the unit in FETCH.
   task automatic doInstr(input string t, input int waits, input logic [7:0] pc0,
                          input logic [7:0] instr, input logic [7:0] pcNext);
      mem[pc0] = instr;
      for (int w = 0; w < waits; w++) begin
         memValid = 1'b0;
         chk({t, "_wait_req"},  32'(imem.IMemReq),   1);
         chk({t, "_wait_addr"}, 32'(imem.IMemAddr),  32'(pc0));
         chk({t, "_wait_exec"}, 32'(ExecEn),         0);
         chk({t, "_wait_ir"},   32'({Opcode, Operand}), 32'(expIR));
         tick();
      end
      memValid = 1'b1;
      chk({t, "_req"},  32'(imem.IMemReq),  1);
      chk({t, "_addr"}, 32'(imem.IMemAddr), 32'(pc0));
      tick();                                   // DECODE
      expIR = instr;
      chk({t, "_ir"},       32'({Opcode, Operand}), 32'(instr));
      chk({t, "_dec_req"},  32'(imem.IMemReq), 0);
      chk({t, "_dec_exec"}, 32'(ExecEn),       0);
      tick();                                   // UPDATE
      chk({t, "_upd_exec"}, 32'(ExecEn), 1);
      chk({t, "_upd_pc"},   32'(PC),     32'(pc0));
      tick();                                   // FETCH or HALT
      chk({t, "_post_exec"}, 32'(ExecEn), 0);
      chk({t, "_pc_next"},   32'(PC),     32'(pcNext));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      memValid = 1'b0;
      setCtrl(0, 0, 0, 0, 8'h00);
      foreach (mem[i]) mem[i] = 8'h00;
      expIR = 8'h00;
      #2;
      checkReset("rst");
      tick();
      reset = 1'b0;

      // Zero-wait NOP, PC+1
      setCtrl(1, 1, 0, 0, 8'h00);
      doInstr("nop", 0, 8'h00, 8'h00, 8'h01);
      // Two wait states
      doInstr("wait2", 2, 8'h01, 8'h35, 8'h02);
      // Immediate jump: 7A -> 0A
      setCtrl(1, 0, 1, 1, 8'h00);
      doInstr("jmpi", 0, 8'h02, 8'h7A, 8'h0A);
      // Register jump: RegData 33
      setCtrl(1, 0, 0, 1, 8'h33);
      doInstr("jmpr", 0, 8'h0A, 8'h41, 8'h33);
      // LoadPC with IncPC: jump wins -> 0F
      setCtrl(1, 1, 1, 1, 8'h00);
      doInstr("prio", 0, 8'h33, 8'h7F, 8'h0F);
      // Jump to FF then increment wraps to 00
      setCtrl(1, 0, 0, 1, 8'hFF);
      doInstr("toff", 0, 8'h0F, 8'h80, 8'hFF);
      setCtrl(1, 1, 0, 0, 8'h00);
      doInstr("wrap", 0, 8'hFF, 8'h00, 8'h00);
      chk("wrap_fetch_addr", 32'(imem.IMemAddr), 0);
      chk("wrap_fetch_req",  32'(imem.IMemReq),  1);

      // HALT: LoadIR=0, IncPC=1 -> PC 1 then frozen
      setCtrl(0, 1, 0, 0, 8'h00);
      doInstr("halt", 0, 8'h00, 8'hF0, 8'h01);
      chk("halt_flag", 32'(Halted),       1);
      chk("halt_req",  32'(imem.IMemReq), 0);
      setCtrl(1, 1, 1, 1, 8'h55);
      for (int i = 0; i < 20; i++) begin
         memValid = ~memValid;
         tick();
         chk("halt_hold_pc",   32'(PC),               1);
         chk("halt_hold_flag", 32'(Halted),           1);
         chk("halt_hold_req",  32'(imem.IMemReq),     0);
         chk("halt_hold_exec", 32'(ExecEn),           0);
         chk("halt_hold_ir",   32'({Opcode, Operand}), 32'h0F0);
      end
      #3;
      reset = 1'b1;
      expIR = 8'h00;
      #1;
      checkReset("halt_rst");
      tick();
      reset = 1'b0;

      // Reset between edges while in DECODE aborts the instruction
      setCtrl(1, 1, 0, 0, 8'h00);
      mem[0] = 8'h35;
      memValid = 1'b1;
      tick();
      chk("abort_dec_ir", 32'({Opcode, Operand}), 32'h35);
      #3;
      reset = 1'b1;
      expIR = 8'h00;
      #1;
      checkReset("abort");
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("abort_hold_exec", 32'(ExecEn), 0);
         chk("abort_hold_pc",   32'(PC),     0);
      end
      reset = 1'b0;
      doInstr("recover", 0, 8'h00, 8'h12, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
